// File: rtl/ram_input_ctrl.sv
// Input-unit RAM sequencer: loads a host word stream into a single-port RAM, then streams it
// back out over valid/ready through a two-entry buffer that hides the one-cycle read latency.
module ram_input_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  rd_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH:0]   stored_len,
    output logic                  busy,
    output logic                  err
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLoad   = 2'd1;
    localparam logic [1:0] StStream = 2'd2;

    localparam logic [ADDR_WIDTH:0] Depth  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   load_target_q, load_target_d;
    logic [ADDR_WIDTH:0]   stored_len_q, stored_len_d;
    logic [ADDR_WIDTH:0]   head_idx_q, head_idx_d;
    logic [1:0]            count_q, count_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic                  err_q, err_d;

    logic       wr_hs, push, pop, issue, load_ok, head_is_last;
    logic [2:0] occ_next;

    assign load_ok      = (load_len != '0) && (load_len <= Depth);
    assign in_ready     = (state_q == StLoad);
    assign wr_hs        = in_valid & in_ready;
    assign ram_we       = wr_hs;
    assign ram_data     = in_data;
    assign busy         = (state_q != StIdle);
    assign err          = err_q;
    assign stored_len   = stored_len_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_data     = buf0_q;
    assign head_is_last = (head_idx_q == stored_len_q - PtrOne);
    assign out_last     = out_valid & head_is_last;
    assign push         = inflight_q;
    assign pop          = out_valid & out_ready;

    // Occupancy the buffer will have next cycle, counting the read already in flight.
    assign occ_next = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue    = (state_q == StStream) && (rd_ptr_q < stored_len_q) && (occ_next < 3'd2);

    always_comb begin
        unique case (state_q)
            StLoad:   ram_addr = wr_ptr_q[ADDR_WIDTH-1:0];
            StStream: ram_addr = rd_ptr_q[ADDR_WIDTH-1:0];
            default:  ram_addr = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        load_target_d = load_target_q;
        stored_len_d  = stored_len_q;
        head_idx_d    = head_idx_q;
        count_d       = count_q;
        inflight_d    = issue;
        buf0_d        = buf0_q;
        buf1_d        = buf1_q;
        err_d         = 1'b0;

        if (issue) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (pop) begin
            head_idx_d = head_idx_q + PtrOne;
        end

        // Head lives in buf0; buf1 only holds a second word while the head is stalled.
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) buf0_d = ram_q;
                else                 buf1_d = ram_q;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                buf0_d  = buf1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    buf0_d = ram_q;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = ram_q;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    if (load_ok) begin
                        load_target_d = load_len;
                        wr_ptr_d      = '0;
                        stored_len_d  = '0;
                        state_d       = StLoad;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (rd_start) begin
                    if (stored_len_q != '0) begin
                        rd_ptr_d   = '0;
                        head_idx_d = '0;
                        count_d    = '0;
                        inflight_d = 1'b0;
                        state_d    = StStream;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (wr_hs) begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    if (wr_ptr_q == load_target_q - PtrOne) begin
                        stored_len_d = load_target_q;
                        state_d      = StIdle;
                    end
                end
            end
            StStream: begin
                if (pop && head_is_last) begin
                    count_d    = '0;
                    inflight_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            load_target_q <= '0;
            stored_len_q  <= '0;
            head_idx_q    <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            buf0_q        <= '0;
            buf1_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            load_target_q <= load_target_d;
            stored_len_q  <= stored_len_d;
            head_idx_q    <= head_idx_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            buf0_q        <= buf0_d;
            buf1_q        <= buf1_d;
            err_q         <= err_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd2));

endmodule

// File: tb/tb_ram_input_ctrl.sv
// Bench for ram_input_ctrl: models the RAM, drives randomized loads/streams and compares
// against a queue of the words the host has stored.
module tb_ram_input_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [6:0] load_len;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       rd_start;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] ram_q;
    logic [6:0] stored_len;
    logic       busy;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [0:63];
    logic [7:0] model_words [$];

    ram_input_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rd_start   (rd_start),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_q      (ram_q),
        .stored_len (stored_len),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered address, read-before-write.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to the middle of the next cycle; inputs set after this apply to that cycle.
    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic load_words(input int n, input bit gaps);
        int sent;
        int guard;
        logic [7:0] w;
        logic [7:0] words [$];
        cycle();
        load_start = 1'b1;
        load_len   = 7'(n);
        cycle();
        load_start = 1'b0;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 20 * n + 20) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            w        = 8'($urandom);
            in_data  = w;
            #1;
            if (in_valid && in_ready) begin
                words.push_back(w);
                sent++;
            end
            cycle();
            guard++;
        end
        in_valid = 1'b0;
        vectors++;
        if (sent != n) begin
            miscompares++;
            $display("FAIL load_timeout: handshakes=%0d required=%0d", sent, n);
        end
        model_words = words;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_start = 1'b0; load_len = '0; in_valid = 1'b0; in_data = '0;
        rd_start = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_last, ram_we, busy, err} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got=%b required=000000",
                     {in_ready, out_valid, out_last, ram_we, busy, err});
        end
        vectors++;
        if (ram_addr !== 6'd0 || out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_addr_data: addr=%0d data=%0h required=0/0", ram_addr, out_data);
        end
        vectors++;
        if (stored_len !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_stored_len: got=%0d required=0", stored_len);
        end
    endtask

    task automatic test_rd_after_reset();
        cycle(); rd_start = 1'b1;
        cycle(); rd_start = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_empty_err: err=%b busy=%b required err=1 busy=0", err, busy);
        end
        cycle(); #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_empty_err_pulse: err=%b required=0", err);
        end
    endtask

    task automatic test_full_load();
        logic [7:0] words [$];
        cycle(); load_start = 1'b1; load_len = 7'd64;
        cycle(); load_start = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_data = 8'(i) ^ 8'hA5;
            #1;
            if (i == 0) begin
                vectors++;
                if (stored_len !== 7'd0) begin
                    miscompares++;
                    $display("FAIL load_entry_len: stored_len=%0d required=0", stored_len);
                end
            end
            vectors++;
            if (in_ready !== 1'b1 || ram_we !== 1'b1 || busy !== 1'b1 ||
                ram_addr !== 6'(i) || ram_data !== (8'(i) ^ 8'hA5)) begin
                miscompares++;
                $display("FAIL full_load_write[%0d]: rdy=%b we=%b busy=%b addr=%0d data=%0h required 1/1/1/%0d/%0h",
                         i, in_ready, ram_we, busy, ram_addr, ram_data, i, 8'(i) ^ 8'hA5);
            end
            words.push_back(8'(i) ^ 8'hA5);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || stored_len !== 7'd64 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL full_load_done: busy=%b stored_len=%0d we=%b required 0/64/0",
                     busy, stored_len, ram_we);
        end
        model_words = words;
    endtask

    task automatic test_load_zero();
        logic [6:0] bad_len [2];
        bad_len[0] = 7'd0;
        bad_len[1] = 7'd65;
        for (int k = 0; k < 2; k++) begin
            cycle(); load_start = 1'b1; load_len = bad_len[k];
            cycle(); load_start = 1'b0;
            #1;
            vectors++;
            if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || stored_len !== 7'd64) begin
                miscompares++;
                $display("FAIL bad_len_%0d: err=%b busy=%b rdy=%b stored_len=%0d required 1/0/0/64",
                         bad_len[k], err, busy, in_ready, stored_len);
            end
        end
        cycle(); #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_len_pulse: err=%b required=0", err);
        end
    endtask

    task automatic test_stream_no_bp();
        cycle(); rd_start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 67; c++) begin
            cycle(); rd_start = 1'b0;
            #1;
            vectors++;
            if (c == 1) begin
                if (busy !== 1'b1 || ram_addr !== 6'd0 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_c1: busy=%b addr=%0d valid=%b required 1/0/0",
                             busy, ram_addr, out_valid);
                end
            end else if (c == 2) begin
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stream_c2: valid=%b busy=%b required 0/1", out_valid, busy);
                end
            end else if (c <= 66) begin
                if (out_valid !== 1'b1 || out_data !== model_words[c-3] ||
                    out_last !== (c == 66)) begin
                    miscompares++;
                    $display("FAIL stream_word[%0d]: valid=%b data=%0h last=%b required 1/%0h/%b",
                             c - 3, out_valid, out_data, out_last, model_words[c-3], c == 66);
                end
            end else begin
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_end: busy=%b valid=%b required 0/0", busy, out_valid);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_load_during_stream();
        int idx;
        int guard;
        cycle(); rd_start = 1'b1; out_ready = 1'b0;
        cycle(); rd_start = 1'b0; load_start = 1'b1; load_len = 7'd3;
        cycle(); load_start = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || stored_len !== 7'd64) begin
            miscompares++;
            $display("FAIL load_in_stream: err=%b busy=%b rdy=%b stored_len=%0d required 0/1/0/64",
                     err, busy, in_ready, stored_len);
        end
        idx = 0;
        guard = 0;
        while (idx < 64 && guard < 200) begin
            cycle(); out_ready = 1'b1;
            #1;
            if (out_valid) begin
                vectors++;
                if (out_data !== model_words[idx]) begin
                    miscompares++;
                    $display("FAIL restream_word[%0d]: got=%0h required=%0h",
                             idx, out_data, model_words[idx]);
                end
                idx++;
            end
            guard++;
        end
        cycle(); out_ready = 1'b0;
        #1;
        vectors++;
        if (idx != 64 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restream_count: words=%0d busy=%b required 64/0", idx, busy);
        end
    endtask

    task automatic test_random_backpressure();
        int lens [4];
        lens[0] = 5;
        for (int k = 1; k < 4; k++) lens[k] = $urandom_range(1, 64);
        for (int k = 0; k < 4; k++) begin
            int n;
            int idx;
            int guard;
            bit stalled;
            logic [7:0] prev_data;
            logic prev_last;
            n = lens[k];
            load_words(n, 1'b1);
            #1;
            vectors++;
            if (stored_len !== 7'(n) || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_load_len: stored_len=%0d busy=%b required %0d/0", stored_len, busy, n);
            end
            cycle(); rd_start = 1'b1; out_ready = 1'b0;
            cycle(); rd_start = 1'b0;
            idx = 0;
            guard = 0;
            stalled = 1'b0;
            prev_data = '0;
            prev_last = 1'b0;
            while (idx < n && guard < 20 * n + 50) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                if (stalled) begin
                    vectors++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                        miscompares++;
                        $display("FAIL bp_stall_hold: valid=%b data=%0h last=%b required 1/%0h/%b",
                                 out_valid, out_data, out_last, prev_data, prev_last);
                    end
                end
                if (out_valid && out_ready) begin
                    vectors++;
                    if (out_data !== model_words[idx] || out_last !== (idx == n - 1)) begin
                        miscompares++;
                        $display("FAIL bp_word[%0d]: data=%0h last=%b required %0h/%b",
                                 idx, out_data, out_last, model_words[idx], idx == n - 1);
                    end
                    idx++;
                end
                stalled   = out_valid && !out_ready;
                prev_data = out_data;
                prev_last = out_last;
                cycle();
                guard++;
            end
            vectors++;
            if (idx != n) begin
                miscompares++;
                $display("FAIL bp_timeout: words=%0d required=%0d", idx, n);
            end
            out_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                #1;
                vectors++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_extra_word: valid=%b busy=%b required 0/0", out_valid, busy);
                end
                cycle();
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] words [$];
        logic [7:0] w;
        cycle(); load_start = 1'b1; rd_start = 1'b1; load_len = 7'd3;
        cycle(); load_start = 1'b0; rd_start = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 ||
            stored_len !== 7'd0) begin
            miscompares++;
            $display("FAIL simul_cmd: rdy=%b busy=%b err=%b valid=%b stored_len=%0d required 1/1/0/0/0",
                     in_ready, busy, err, out_valid, stored_len);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            in_data = w;
            words.push_back(w);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || stored_len !== 7'd3 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_load_done: busy=%b stored_len=%0d valid=%b required 0/3/0",
                     busy, stored_len, out_valid);
        end
        model_words = words;
    endtask

    task automatic test_reset_mid_stream();
        load_words(8, 1'b0);
        cycle(); rd_start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cycle(); rd_start = 1'b0;
        end
        cycle(); rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== model_words[1]) begin
            miscompares++;
            $display("FAIL mid_stream_c4: busy=%b valid=%b data=%0h required 1/1/%0h",
                     busy, out_valid, out_data, model_words[1]);
        end
        cycle(); rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || stored_len !== 7'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_stream_reset: valid=%b stored_len=%0d busy=%b required 0/0/0",
                     out_valid, stored_len, busy);
        end
        cycle(); rd_start = 1'b1;
        cycle(); rd_start = 1'b0; out_ready = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_rd: err=%b busy=%b required 1/0", err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_rd_after_reset();
        test_full_load();
        test_load_zero();
        test_stream_no_bp();
        test_load_during_stream();
        test_random_backpressure();
        test_simultaneous();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
